micro_tile_select_ctrl: RTL and testbench

Sequencer that sits upstream of the micro-tile container and turns the raw tile-select pins into a glitch-free, safely sequenced selection. It synchronises and debounces the requested tile index. On a change it gates all tile clocks, switches the select, and holds the newly selected tile in reset for a fixed window before letting it run. Its outputs drive the container's tile select, per-tile clock enables, and tile reset, replacing direct use of the pins.

---
 rtl/micro_tile_pkg.sv | 21 ++
 rtl/micro_tile_select_ctrl_sel_sync_filter.sv | 58 +++++
 rtl/micro_tile_select_ctrl.sv | 126 ++++++++++++
 tb/tb_micro_tile_select_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/micro_tile_pkg.sv
// Shared types and helpers for the micro-tile select sequencer.
package micro_tile_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_GATE
  } tile_ctrl_state_t;

  localparam int TILE_N_DEFAULT     = 4;
  localparam int TILE_SEL_W_DEFAULT = 2;

  // Bit bit_i of onehot(idx).
  function automatic logic onehot_sel(
    input int unsigned idx,
    input int unsigned bit_i
  );
    return idx == bit_i;
  endfunction

endpackage

// File: rtl/micro_tile_select_ctrl_sel_sync_filter.sv
// Select-pin synchroniser followed by a consecutive-sample stability filter.
module sel_sync_filter #(
  parameter int SEL_W         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [SEL_W-1:0] sel_req,
  output logic [SEL_W-1:0] stable_sel
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES - 1);

  logic [SEL_W-1:0] sync_q [SYNC_STAGES];
  logic [SEL_W-1:0] sel_sync;
  logic [SEL_W-1:0] cand;
  logic [CW-1:0]    stable_cnt;
  logic [CW-1:0]    cnt_n;
  logic             accept;

  assign sel_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else if (ena) begin
      sync_q[0] <= sel_req;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // Run length including this sample is cnt_n+1; accept at STABLE_CYCLES.
  always_comb begin
    cnt_n = '0;
    if (sel_sync == cand)
      cnt_n = (stable_cnt == SAT) ? SAT : stable_cnt + CW'(1);
    accept = (cnt_n == SAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand       <= '0;
      stable_cnt <= '0;
      stable_sel <= '0;
    end else if (ena) begin
      cand       <= sel_sync;
      stable_cnt <= cnt_n;
      if (accept)
        stable_sel <= sel_sync;
    end
  end

endmodule

// File: rtl/micro_tile_select_ctrl.sv
// Tile select sequencer: gate clocks, switch select, hold new tile in reset.
module micro_tile_select_ctrl
  import micro_tile_pkg::*;
#(
  parameter int N_TILES       = TILE_N_DEFAULT,
  parameter int SEL_W         = TILE_SEL_W_DEFAULT,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GATE_CYCLES   = 2,
  parameter int RST_CYCLES    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [SEL_W-1:0]   sel_req,
  output logic [SEL_W-1:0]   sel,
  output logic [N_TILES-1:0] tile_clk_en,
  output logic               tile_rst,
  output logic               busy,
  output logic               switch_done,
  output logic [7:0]         switch_count
);

  localparam int CMAX =
    (GATE_CYCLES > RST_CYCLES) ? GATE_CYCLES : RST_CYCLES;
  localparam int CNT_W = $clog2(CMAX) + 1;
  localparam logic [CNT_W-1:0] GATE_LD = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYCLES - 1);

  tile_ctrl_state_t   state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [SEL_W-1:0]   stable_sel;
  logic [SEL_W-1:0]   target_q, target_n, sel_n;
  logic [7:0]         count_n;
  logic               done_q, done_n;
  logic               trst_q, trst_n;
  logic               busy_q, busy_n;
  logic [N_TILES-1:0] en_q, en_n;

  sel_sync_filter #(
    .SEL_W        (SEL_W),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .sel_req   (sel_req),
    .stable_sel(stable_sel)
  );

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    sel_n    = sel;
    target_n = target_q;
    count_n  = switch_count;
    done_n   = done_q;
    if (ena) begin
      done_n = 1'b0;
      unique case (state_q)
        ST_RESET: begin
          if (cnt_q == '0) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            count_n = switch_count + 8'd1;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (stable_sel != sel) begin
            state_n  = ST_GATE;
            target_n = stable_sel;
            cnt_n    = GATE_LD;
          end
        end
        ST_GATE: begin
          if (cnt_q == '0) begin
            state_n = ST_RESET;
            sel_n   = target_q;
            cnt_n   = RST_LD;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        default: state_n = ST_RESET;
      endcase
    end
    // Outputs are decoded from the next state so they leave a flop.
    trst_n = (state_n != ST_IDLE);
    busy_n = (state_n != ST_IDLE);
    for (int i = 0; i < N_TILES; i++)
      en_n[i] = (state_n != ST_GATE) && onehot_sel(32'(sel_n), i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RESET;
      cnt_q        <= RST_LD;
      sel          <= '0;
      target_q     <= '0;
      switch_count <= '0;
      done_q       <= 1'b0;
      trst_q       <= 1'b1;
      busy_q       <= 1'b1;
      en_q         <= N_TILES'(1);
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      sel          <= sel_n;
      target_q     <= target_n;
      switch_count <= count_n;
      done_q       <= done_n;
      trst_q       <= trst_n;
      busy_q       <= busy_n;
      en_q         <= en_n;
    end
  end

  assign tile_rst    = trst_q;
  assign busy        = busy_q;
  assign tile_clk_en = en_q & {N_TILES{ena}};
  assign switch_done = done_q & ena;

endmodule

// File: tb/tb_micro_tile_select_ctrl.sv
// Directed bench for micro_tile_select_ctrl with default parameters.
module tb_micro_tile_select_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] sel_req;
  logic [1:0] sel;
  logic [3:0] tile_clk_en;
  logic       tile_rst;
  logic       busy;
  logic       switch_done;
  logic [7:0] switch_count;

  int n_vec = 0;
  int n_err = 0;

  micro_tile_select_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .sel_req     (sel_req),
    .sel         (sel),
    .tile_clk_en (tile_clk_en),
    .tile_rst    (tile_rst),
    .busy        (busy),
    .switch_done (switch_done),
    .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic got;
    rst = 1'b1;
    ena = 1'b1;
    sel_req = 2'd0;

    tick(3);
    chk("rst_trst", 32'(tile_rst), 1);
    chk("rst_en", 32'(tile_clk_en), 4'b0001);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_done", 32'(switch_done), 0);
    chk("rst_cnt", 32'(switch_count), 0);
    chk("rst_sel", 32'(sel), 0);

    rst = 1'b0;
    tick(7);
    chk("po_busy7", 32'(busy), 1);
    chk("po_trst7", 32'(tile_rst), 1);
    chk("po_en7", 32'(tile_clk_en), 4'b0001);
    tick(1);
    chk("po_done", 32'(switch_done), 1);
    chk("po_count", 32'(switch_count), 1);
    chk("po_trst", 32'(tile_rst), 0);
    chk("po_busy", 32'(busy), 0);
    tick(1);
    chk("po_done_off", 32'(switch_done), 0);

    sel_req = 2'd2;
    tick(1);
    tick(5);
    chk("sw_e5_busy", 32'(busy), 0);
    chk("sw_e5_en", 32'(tile_clk_en), 4'b0001);
    tick(1);
    chk("sw_e6_busy", 32'(busy), 1);
    chk("sw_e6_en", 32'(tile_clk_en), 0);
    tick(1);
    chk("sw_e7_en", 32'(tile_clk_en), 0);
    chk("sw_e7_sel", 32'(sel), 0);
    tick(1);
    chk("sw_e8_sel", 32'(sel), 2);
    chk("sw_e8_en", 32'(tile_clk_en), 4'b0100);
    chk("sw_e8_trst", 32'(tile_rst), 1);
    tick(7);
    chk("sw_e15_done", 32'(switch_done), 0);
    chk("sw_e15_busy", 32'(busy), 1);
    tick(1);
    chk("sw_e16_done", 32'(switch_done), 1);
    chk("sw_e16_count", 32'(switch_count), 2);
    chk("sw_e16_trst", 32'(tile_rst), 0);
    chk("sw_e16_en", 32'(tile_clk_en), 4'b0100);

    sel_req = 2'd3;
    tick(2);
    sel_req = 2'd2;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("gl_busy", 32'(busy), 0);
      chk("gl_done", 32'(switch_done), 0);
    end
    chk("gl_stable", 32'(dut.u_filter.stable_sel), 2);
    chk("gl_sel", 32'(sel), 2);

    sel_req = 2'd1;
    tick(1);
    tick(9);
    chk("rt_sel1", 32'(sel), 1);
    chk("rt_trst", 32'(tile_rst), 1);
    sel_req = 2'd3;
    tick(7);
    chk("rt_done1", 32'(switch_done), 1);
    chk("rt_count1", 32'(switch_count), 3);
    chk("rt_sel_keep", 32'(sel), 1);
    tick(1);
    chk("rt_gate_busy", 32'(busy), 1);
    chk("rt_gate_en", 32'(tile_clk_en), 0);
    chk("rt_gate_done", 32'(switch_done), 0);
    tick(2);
    chk("rt_sel3", 32'(sel), 3);
    chk("rt_en3", 32'(tile_clk_en), 4'b1000);
    tick(8);
    chk("rt_done2", 32'(switch_done), 1);
    chk("rt_count2", 32'(switch_count), 4);
    chk("rt_busy", 32'(busy), 0);

    sel_req = 2'd0;
    tick(1);
    tick(10);
    chk("fz_cnt5", 32'(dut.cnt_q), 5);
    chk("fz_en_pre", 32'(tile_clk_en), 4'b0001);
    ena = 1'b0;
    #1;
    chk("fz_en_gated", 32'(tile_clk_en), 0);
    tick(10);
    chk("fz_en_hold", 32'(tile_clk_en), 0);
    chk("fz_cnt_hold", 32'(dut.cnt_q), 5);
    chk("fz_trst", 32'(tile_rst), 1);
    chk("fz_busy", 32'(busy), 1);
    ena = 1'b1;
    #1;
    chk("fz_en_back", 32'(tile_clk_en), 4'b0001);
    tick(5);
    chk("fz_r5_busy", 32'(busy), 1);
    chk("fz_r5_done", 32'(switch_done), 0);
    tick(1);
    chk("fz_done", 32'(switch_done), 1);
    chk("fz_busy_off", 32'(busy), 0);
    chk("fz_count", 32'(switch_count), 5);

    for (int i = 0; i < 251; i++) begin
      sel_req = (i % 2 == 0) ? 2'd1 : 2'd0;
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        tick(1);
        if (switch_done) got = 1'b1;
      end
      chk("wrap_done", 32'(got), 1);
      chk("wrap_count", 32'(switch_count), (6 + i) % 256);
    end
    chk("wrap_zero", 32'(switch_count), 0);
    chk("wrap_sel", 32'(sel), 1);

    sel_req = 2'd2;
    tick(1);
    tick(6);
    chk("ab_gate_busy", 32'(busy), 1);
    chk("ab_gate_en", 32'(tile_clk_en), 0);
    rst = 1'b1;
    tick(1);
    chk("ab_sel", 32'(sel), 0);
    chk("ab_count", 32'(switch_count), 0);
    chk("ab_busy", 32'(busy), 1);
    chk("ab_trst", 32'(tile_rst), 1);
    chk("ab_en", 32'(tile_clk_en), 4'b0001);
    chk("ab_cnt", 32'(dut.cnt_q), 7);
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
